// File: rtl/sbus_ram_slave_pkg.sv
// rtl/sbus_ram_slave_pkg.sv - shared sbus responder types, widths and write-mask legality check
package sbus_ram_slave_pkg;

  localparam int W_ADDR = 32;
  localparam int W_DATA = 32;

  typedef enum logic [1:0] {SR_IDLE, SR_WAIT, SR_RESP} sbus_rsp_state;

  // Only whole-word, aligned-halfword-pair and single-byte lane masks are meaningful.
  function automatic logic sbus_wen_legal(input logic [3:0] wen);
    case (wen)
      4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sbus_ram_array.sv
// rtl/sbus_ram_array.sv - single-port synchronous word RAM with byte write enables, read-before-write
module sbus_ram_array
  import sbus_ram_slave_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic [3:0]        we,
  input  logic [AW-1:0]     idx,
  input  logic [W_DATA-1:0] wdata,
  output logic [W_DATA-1:0] q
);

  logic [W_DATA-1:0] mem [DEPTH];

  // Byte-lane writes; contents survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // Registered read; samples the pre-write word when read and write share an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else if (re) q <= mem[idx];
  end

endmodule

// File: rtl/sbus_ram_slave.sv
// rtl/sbus_ram_slave.sv - sbus request/stall responder backed by on-chip RAM with fixed wait states
module sbus_ram_slave
  import sbus_ram_slave_pkg::*;
#(
  parameter int                DEPTH   = 1024,
  parameter int                LATENCY = 2,
  parameter logic [W_ADDR-1:0] BASE    = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [3:0]        wen,
  input  logic [W_ADDR-1:0] addr,
  input  logic [W_DATA-1:0] wdata,
  output logic [W_DATA-1:0] rdata,
  output logic              stall,
  output logic              err
);

  localparam int AW = $clog2(DEPTH);

  sbus_rsp_state     state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              access;
  logic              err_d;
  logic              err_q;
  logic [W_ADDR-1:0] off;
  logic [AW-1:0]     word;
  logic [W_DATA-1:0] ram_q;

  assign off  = addr - BASE;
  assign word = off[AW+1:2];

  // Fault decode: window overrun (offset wraps below BASE too), misaligned word access, odd lane masks.
  always_comb begin
    err_d = 1'b0;
    if ({1'b0, off} >= (33'(DEPTH) << 2)) err_d = 1'b1;
    if ((addr[1:0] != 2'b00) && ((wen == 4'h0) || (wen == 4'hF))) err_d = 1'b1;
    if (!sbus_wen_legal(wen)) err_d = 1'b1;
  end

  // State and wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SR_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, stall and the single-cycle access strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    access  = 1'b0;
    case (state_q)
      SR_IDLE: begin
        stall = en;
        if (en) begin
          if (LATENCY == 0) begin
            access  = 1'b1;
            state_d = SR_RESP;
          end else begin
            cnt_d   = 4'(LATENCY - 1);
            state_d = SR_WAIT;
          end
        end
      end
      SR_WAIT: begin
        stall = 1'b1;
        if (!en) begin
          cnt_d   = 4'd0;
          state_d = SR_IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = SR_RESP;
        end
      end
      SR_RESP: begin
        stall   = 1'b0;
        state_d = SR_IDLE;
      end
      default: state_d = SR_IDLE;
    endcase
  end

  // Error flag is captured with the access and held until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else if (access) err_q <= err_d;
  end

  sbus_ram_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .re   (access && !err_d),
    .we   ((access && !err_d) ? wen : 4'h0),
    .idx  (word),
    .wdata(wdata),
    .q    (ram_q)
  );

  // A faulted access reports zero data; otherwise the last read word is held.
  assign rdata = err_q ? '0 : ram_q;
  assign err   = err_q;

endmodule

// File: tb/tb_sbus_ram_slave.sv
// tb/tb_sbus_ram_slave.sv - randomized self-checking bench for sbus_ram_slave (LATENCY=2 and LATENCY=0 instances)
module tb_sbus_ram_slave;

  localparam int          DEP0  = 1024;
  localparam int          LAT0  = 2;
  localparam logic [31:0] BASE0 = 32'h0;
  localparam int          DEP1  = 16;
  localparam int          LAT1  = 0;
  localparam logic [31:0] BASE1 = 32'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en    [2];
  logic [3:0]  wen   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        stall [2];
  logic        err   [2];

  int checks   = 0;
  int failures = 0;

  logic [31:0] mdl [2][1024];
  bit          vld [2][1024];

  always #5 clk = ~clk;

  sbus_ram_slave #(.DEPTH(DEP0), .LATENCY(LAT0), .BASE(BASE0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en[0]), .wen(wen[0]), .addr(addr[0]), .wdata(wdata[0]),
    .rdata(rdata[0]), .stall(stall[0]), .err(err[0])
  );

  sbus_ram_slave #(.DEPTH(DEP1), .LATENCY(LAT1), .BASE(BASE1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en[1]), .wen(wen[1]), .addr(addr[1]), .wdata(wdata[1]),
    .rdata(rdata[1]), .stall(stall[1]), .err(err[1])
  );

  function automatic int dep_of(input int which);
    return (which == 0) ? DEP0 : DEP1;
  endfunction

  function automatic int lat_of(input int which);
    return (which == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [31:0] base_of(input int which);
    return (which == 0) ? BASE0 : BASE1;
  endfunction

  // Reference: decide fault from the addressing rules, return old word, apply masked write.
  function automatic void model_access(input int which, input logic [3:0] w, input logic [31:0] a,
                                       input logic [31:0] d, output logic e, output logic [31:0] rd,
                                       output bit known);
    logic [31:0] off;
    int idx;
    bit oor, mis, legal;
    off   = a - base_of(which);
    oor   = off >= 32'(dep_of(which) * 4);
    mis   = (a[1:0] != 2'b00) && (w == 4'h0 || w == 4'hF);
    legal = w inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    e     = oor || mis || !legal;
    rd    = 32'h0;
    known = 1'b1;
    if (!e) begin
      idx   = int'(off >> 2);
      rd    = mdl[which][idx];
      known = vld[which][idx];
      for (int i = 0; i < 4; i++) if (w[i]) mdl[which][idx][8*i +: 8] = d[8*i +: 8];
      if (w == 4'hF) vld[which][idx] = 1'b1;
    end
  endfunction

  // Drives one request starting just after a posedge; returns samples taken until stall fell.
  task automatic do_req(input int which, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int cyc);
    bit done;
    en[which] = 1'b1; wen[which] = w; addr[which] = a; wdata[which] = d;
    cyc = 0; rd = 32'h0; e = 1'b0; done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!stall[which]) begin
        done = 1'b1;
        rd = rdata[which];
        e = err[which];
      end
    end
    @(posedge clk); #1;
    en[which] = 1'b0; wen[which] = 4'h0;
  endtask

  task automatic run_op(input int which, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                        output logic exp_e, output logic [31:0] exp_rd, output bit known,
                        output logic [31:0] got_rd, output logic got_e, output int cyc);
    model_access(which, w, a, d, exp_e, exp_rd, known);
    do_req(which, w, a, d, got_rd, got_e, cyc);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      checks++; if (rdata[k] !== 32'h0) begin failures++; $display("FAIL reset_rdata%0d got=%h exp=0", k, rdata[k]); end
      checks++; if (err[k] !== 1'b0) begin failures++; $display("FAIL reset_err%0d got=%b exp=0", k, err[k]); end
      checks++; if (stall[k] !== 1'b0) begin failures++; $display("FAIL reset_stall%0d got=%b exp=0", k, stall[k]); end
    end
  endtask

  task automatic test_read_latency();
    logic e_exp, e_got; logic [31:0] r_exp, r_got; bit kn; int cyc;
    run_op(0, 4'hF, 32'h10, 32'hDEADBEEF, e_exp, r_exp, kn, r_got, e_got, cyc);
    checks++; if (e_got !== 1'b0) begin failures++; $display("FAIL preload_err got=%b exp=0", e_got); end
    run_op(0, 4'h0, 32'h10, 32'h0, e_exp, r_exp, kn, r_got, e_got, cyc);
    checks++; if (cyc !== 4) begin failures++; $display("FAIL read_latency got=%0d exp=4", cyc); end
    checks++; if (r_got !== 32'hDEADBEEF) begin failures++; $display("FAIL read_data got=%h exp=deadbeef", r_got); end
    checks++; if (e_got !== 1'b0) begin failures++; $display("FAIL read_err got=%b exp=0", e_got); end
  endtask

  task automatic test_byte_write();
    logic e_exp, e_got; logic [31:0] r_exp, r_got; bit kn; int cyc;
    run_op(0, 4'hF, 32'h20, 32'h11223344, e_exp, r_exp, kn, r_got, e_got, cyc);
    run_op(0, 4'b0010, 32'h20, 32'h0000AB00, e_exp, r_exp, kn, r_got, e_got, cyc);
    checks++; if (r_got !== 32'h11223344) begin failures++; $display("FAIL bytewr_old got=%h exp=11223344", r_got); end
    run_op(0, 4'h0, 32'h20, 32'h0, e_exp, r_exp, kn, r_got, e_got, cyc);
    checks++; if (r_got !== 32'h1122AB44) begin failures++; $display("FAIL bytewr_readback got=%h exp=1122ab44", r_got); end
  endtask

  task automatic test_errors();
    logic e_exp, e_got; logic [31:0] r_exp, r_got; bit kn; int cyc;
    run_op(0, 4'h0, 32'h1002, 32'h0, e_exp, r_exp, kn, r_got, e_got, cyc);
    checks++; if (e_got !== 1'b1 || r_got !== 32'h0) begin failures++; $display("FAIL err_misaligned got=%b/%h exp=1/0", e_got, r_got); end
    run_op(0, 4'hF, BASE0 + DEP0 * 4, 32'hCAFEF00D, e_exp, r_exp, kn, r_got, e_got, cyc);
    checks++; if (e_got !== 1'b1 || r_got !== 32'h0) begin failures++; $display("FAIL err_range got=%b/%h exp=1/0", e_got, r_got); end
    run_op(0, 4'b0101, 32'h20, 32'hFFFFFFFF, e_exp, r_exp, kn, r_got, e_got, cyc);
    checks++; if (e_got !== 1'b1) begin failures++; $display("FAIL err_mask got=%b exp=1", e_got); end
    run_op(0, 4'hF, 32'h21, 32'hFFFFFFFF, e_exp, r_exp, kn, r_got, e_got, cyc);
    checks++; if (e_got !== 1'b1) begin failures++; $display("FAIL err_misaligned_wr got=%b exp=1", e_got); end
    run_op(0, 4'h0, 32'h20, 32'h0, e_exp, r_exp, kn, r_got, e_got, cyc);
    checks++; if (r_got !== 32'h1122AB44 || e_got !== 1'b0) begin failures++; $display("FAIL err_mem_unchanged got=%h exp=1122ab44", r_got); end
  endtask

  task automatic test_abort();
    logic e_exp, e_got; logic [31:0] r_exp, r_got; bit kn; int cyc;
    en[0] = 1'b1; wen[0] = 4'hF; addr[0] = 32'h20; wdata[0] = 32'h55555555;
    @(posedge clk); #1;
    @(posedge clk); #1;
    en[0] = 1'b0;
    @(negedge clk);
    checks++; if (stall[0] !== 1'b1) begin failures++; $display("FAIL abort_wait_stall got=%b exp=1", stall[0]); end
    @(posedge clk); #1;
    wen[0] = 4'h0;
    @(negedge clk);
    checks++; if (stall[0] !== 1'b0) begin failures++; $display("FAIL abort_idle_stall got=%b exp=0", stall[0]); end
    checks++; if (rdata[0] !== 32'h1122AB44 || err[0] !== 1'b0) begin failures++; $display("FAIL abort_hold got=%h/%b exp=1122ab44/0", rdata[0], err[0]); end
    @(posedge clk); #1;
    run_op(0, 4'h0, 32'h20, 32'h0, e_exp, r_exp, kn, r_got, e_got, cyc);
    checks++; if (r_got !== 32'h1122AB44) begin failures++; $display("FAIL abort_no_write got=%h exp=1122ab44", r_got); end
  endtask

  task automatic test_reset_mid_wait();
    logic e_exp, e_got; logic [31:0] r_exp, r_got; bit kn; int cyc;
    en[0] = 1'b1; wen[0] = 4'hF; addr[0] = 32'h20; wdata[0] = 32'h99999999;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (stall[0] !== 1'b1) begin failures++; $display("FAIL rst_stall_follows_en got=%b exp=1", stall[0]); end
    checks++; if (rdata[0] !== 32'h0 || err[0] !== 1'b0) begin failures++; $display("FAIL rst_outputs got=%h/%b exp=0/0", rdata[0], err[0]); end
    en[0] = 1'b0; wen[0] = 4'h0;
    #1;
    checks++; if (stall[0] !== 1'b0) begin failures++; $display("FAIL rst_stall_idle got=%b exp=0", stall[0]); end
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(0, 4'h0, 32'h20, 32'h0, e_exp, r_exp, kn, r_got, e_got, cyc);
    checks++; if (r_got !== 32'h1122AB44) begin failures++; $display("FAIL rst_no_write got=%h exp=1122ab44", r_got); end
  endtask

  task automatic test_back_to_back();
    logic e_exp, e_got; logic [31:0] r_exp, r_got; bit kn; int cyc;
    logic [31:0] vals [3];
    for (int k = 0; k < 3; k++) begin
      vals[k] = $urandom;
      run_op(1, 4'hF, BASE1 + 32'(k * 4), vals[k], e_exp, r_exp, kn, r_got, e_got, cyc);
      checks++; if (cyc !== 2 || e_got !== 1'b0) begin failures++; $display("FAIL b2b_preload%0d cyc=%0d err=%b exp=2/0", k, cyc, e_got); end
    end
    en[1] = 1'b1; wen[1] = 4'h0; addr[1] = BASE1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (stall[1] !== 1'b1) begin failures++; $display("FAIL b2b_stall%0d got=%b exp=1", k, stall[1]); end
      @(negedge clk);
      checks++;
      if (stall[1] !== 1'b0 || rdata[1] !== vals[k] || err[1] !== 1'b0) begin
        failures++; $display("FAIL b2b_resp%0d stall=%b data=%h err=%b exp=0/%h/0", k, stall[1], rdata[1], err[1], vals[k]);
      end
      @(posedge clk); #1;
      addr[1] = BASE1 + 32'((k + 1) * 4);
    end
    en[1] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic e_exp, e_got; logic [31:0] r_exp, r_got, a, d; bit kn; int cyc, which, sel;
    logic [3:0] masks [15];
    masks = '{4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'h5, 4'h6, 4'h9, 4'hA};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        run_op(k, 4'hF, base_of(k) + 32'(i * 4), $urandom, e_exp, r_exp, kn, r_got, e_got, cyc);
      end
    end
    for (int n = 0; n < 120; n++) begin
      which = int'($urandom_range(0, 1));
      d = $urandom;
      sel = int'($urandom_range(0, 9));
      if (sel < 6) a = base_of(which) + 32'($urandom_range(0, 7) * 4);
      else if (sel == 6) a = base_of(which) + 32'($urandom_range(0, 31));
      else if (sel == 7) a = base_of(which) + 32'(dep_of(which) * 4) + 32'($urandom_range(0, 3) * 4);
      else if (sel == 8) a = base_of(which) - 32'h4;
      else a = {$urandom} & 32'hFFFF_FFFC;
      run_op(which, masks[$urandom_range(0, 14)], a, d, e_exp, r_exp, kn, r_got, e_got, cyc);
      checks++; if (cyc !== lat_of(which) + 2) begin failures++; $display("FAIL rnd_latency n=%0d inst=%0d got=%0d exp=%0d", n, which, cyc, lat_of(which) + 2); end
      checks++; if (e_got !== e_exp) begin failures++; $display("FAIL rnd_err n=%0d inst=%0d addr=%h got=%b exp=%b", n, which, a, e_got, e_exp); end
      if (kn) begin
        checks++; if (r_got !== r_exp) begin failures++; $display("FAIL rnd_rdata n=%0d inst=%0d addr=%h got=%h exp=%h", n, which, a, r_got, r_exp); end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      en[k] = 1'b0; wen[k] = 4'h0; addr[k] = 32'h0; wdata[k] = 32'h0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    test_reset();
    @(posedge clk); #1;
    test_read_latency();
    test_byte_write();
    test_errors();
    test_abort();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
